uart_rx_framer: RTL and testbench



---
 rtl/uart_rx_framer.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_framer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framer.sv
// UART receive framer: oversampled majority-vote receiver with a one-entry valid/ready holding register.
// Optional even-parity bit compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_framer #(
   parameter int CLOCK_RATE = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_Rx_Data,
   input  logic       i_Rx_Ready,
   output logic       o_Rx_Valid,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Frame_Err,
   output logic       o_Parity_Err,
   output logic       o_Overrun,
   output logic       o_Rx_Busy
);

   localparam int DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TW  = $clog2(OVERSAMPLE);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_SMP_A  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_SMP_B  = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_DECIDE = TW'(OVERSAMPLE / 2 + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

   state_t          state;
   state_t          state_next;
   logic            sync1;
   logic            rx_s;
   logic [DW-1:0]   div_cnt;
   logic [TW-1:0]   tcnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            samp_a;
   logic            samp_b;
   logic            tick;
   logic            at_decide;
   logic            at_bound;
   logic            vote;
   logic            done;
   logic            busy_next;
`ifdef UART_RX_PARITY_EN
   logic            par_err;
`endif

   assign tick      = (state != IDLE) && (div_cnt == DIV_LAST);
   assign at_decide = tick && (tcnt == T_DECIDE);
   assign at_bound  = tick && (tcnt == T_LAST);
   assign vote      = majority3(samp_a, samp_b, rx_s);

   // Two-flop synchronizer for the asynchronous line; idles high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= i_Rx_Data;
         rx_s  <= sync1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (!rx_s) state_next = START;
            else       state_next = IDLE;
         end
         START: begin
            if (at_decide && vote) state_next = IDLE;
            else if (at_bound)     state_next = DATA;
            else                   state_next = START;
         end
         DATA: begin
            if (at_bound && (bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
            end else begin
               state_next = DATA;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (at_bound) state_next = STOP;
            else          state_next = PARITY;
         end
`endif
         STOP: begin
            // Leave at the decision point so a back-to-back start edge is not missed.
            if (at_decide) state_next = IDLE;
            else           state_next = STOP;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: frame completion strobe and next busy value.
   always_comb begin
      done      = 1'b0;
      busy_next = 1'b0;
      if ((state == STOP) && at_decide) done = 1'b1;
      else                              done = 1'b0;
      if (state_next != IDLE) busy_next = 1'b1;
      else                    busy_next = 1'b0;
   end

   // Baud divider and per-bit tick counter, both parked at zero while idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= {DW{1'b0}};
         tcnt    <= {TW{1'b0}};
      end else if (state == IDLE) begin
         div_cnt <= {DW{1'b0}};
         tcnt    <= {TW{1'b0}};
      end else begin
         div_cnt <= (div_cnt == DIV_LAST) ? {DW{1'b0}} : div_cnt + DW'(1);
         if (tick) tcnt <= (tcnt == T_LAST) ? {TW{1'b0}} : tcnt + TW'(1);
      end
   end

   // Vote samples, data shift register and bit counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         samp_a  <= 1'b1;
         samp_b  <= 1'b1;
         shreg   <= 8'h00;
         bit_cnt <= 3'd0;
      end else begin
         if (tick && (tcnt == T_SMP_A)) samp_a <= rx_s;
         if (tick && (tcnt == T_SMP_B)) samp_b <= rx_s;
         if ((state == DATA) && at_decide) shreg <= {vote, shreg[7:1]};
         if (state != DATA)  bit_cnt <= 3'd0;
         else if (at_bound)  bit_cnt <= bit_cnt + 3'd1;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Pending parity error for the frame in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         par_err <= 1'b0;
      end else if (state == START) begin
         par_err <= 1'b0;
      end else if ((state == PARITY) && at_decide) begin
         par_err <= (vote != even_parity(shreg));
      end
   end
`endif

   // One-entry holding register with overrun tracking.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_Rx_Valid   <= 1'b0;
         o_Rx_Byte    <= 8'h00;
         o_Frame_Err  <= 1'b0;
         o_Parity_Err <= 1'b0;
         o_Overrun    <= 1'b0;
      end else if (done) begin
         if (!o_Rx_Valid || i_Rx_Ready) begin
            o_Rx_Valid  <= 1'b1;
            o_Rx_Byte   <= shreg;
            o_Frame_Err <= ~vote;
`ifdef UART_RX_PARITY_EN
            o_Parity_Err <= par_err;
`else
            o_Parity_Err <= 1'b0;
`endif
            o_Overrun   <= 1'b0;
         end else begin
            o_Overrun   <= 1'b1;
         end
      end else if (o_Rx_Valid && i_Rx_Ready) begin
         o_Rx_Valid <= 1'b0;
         o_Overrun  <= 1'b0;
      end
   end

   // Registered busy indicator tracks the state register exactly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) o_Rx_Busy <= 1'b0;
      else          o_Rx_Busy <= busy_next;
   end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed self-checking bench for uart_rx_framer at 160 clk per bit.
module tb_uart_rx_framer;

   localparam int BIT = 160;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rx;
   logic       ready;
   logic       valid;
   logic [7:0] rbyte;
   logic       fe;
   logic       pe;
   logic       ov;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int cap_cnt  = 0;
   int cap_cyc  = 0;
   int start_cyc = 0;
   logic [7:0] cap_byte = 8'h00;
   logic       cap_fe   = 1'b0;
   logic       cap_pe   = 1'b0;

   uart_rx_framer #(
      .CLOCK_RATE(1600000),
      .BAUD_RATE (10000),
      .OVERSAMPLE(16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_Rx_Data   (rx),
      .i_Rx_Ready  (ready),
      .o_Rx_Valid  (valid),
      .o_Rx_Byte   (rbyte),
      .o_Frame_Err (fe),
      .o_Parity_Err(pe),
      .o_Overrun   (ov),
      .o_Rx_Busy   (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every accepted byte, sampled mid-cycle.
   always @(negedge clk) begin
      if (valid && ready) begin
         cap_cnt  <= cap_cnt + 1;
         cap_cyc  <= cyc;
         cap_byte <= rbyte;
         cap_fe   <= fe;
         cap_pe   <= pe;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                             input int glitch_bit, input bit chk_busy);
      rx = 1'b0;
      start_cyc = cyc;
      if (chk_busy) begin
         wait_n(2);
         chk("busy_before", {31'd0, busy}, 32'd0);
         wait_n(1);
         chk("busy_rise", {31'd0, busy}, 32'd1);
         wait_n(BIT - 3);
      end else begin
         wait_n(BIT);
      end
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         if (glitch_bit == i) begin
            wait_n(85);
            rx = ~d[i];
            wait_n(1);
            rx = d[i];
            wait_n(BIT - 86);
         end else begin
            wait_n(BIT);
         end
      end
`ifdef UART_RX_PARITY_EN
      rx = par_b;
      wait_n(BIT);
`endif
      rx = stop_b;
      wait_n(BIT);
      rx = 1'b1;
   endtask

   initial begin
      int n0;
      int lat;
      bit seen_low;
      reset_n = 1'b0;
      rx      = 1'b1;
      ready   = 1'b1;
      wait_n(3);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_byte",  {24'd0, rbyte}, 32'h00);
      chk("rst_fe",    {31'd0, fe},    32'd0);
      chk("rst_pe",    {31'd0, pe},    32'd0);
      chk("rst_ov",    {31'd0, ov},    32'd0);
      chk("rst_busy",  {31'd0, busy},  32'd0);
      reset_n = 1'b1;
      wait_n(20);

      // Basic receive of 0xA5.
      n0 = cap_cnt;
      send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b1);
      wait_n(20);
      lat = cap_cyc - start_cyc;
      chk("a5_count", cap_cnt - n0, 32'd1);
      chk("a5_byte",  {24'd0, cap_byte}, 32'hA5);
      chk("a5_fe",    {31'd0, cap_fe}, 32'd0);
      chk("a5_pe",    {31'd0, cap_pe}, 32'd0);
      chk("a5_lat",   {31'd0, (lat >= 1510 && lat <= 1560)}, 32'd1);
      chk("a5_valid_gone", {31'd0, valid}, 32'd0);

      // False start: 40 clk low pulse.
      n0 = cap_cnt;
      rx = 1'b0;
      wait_n(40);
      rx = 1'b1;
      seen_low = 1'b0;
      for (int i = 0; i < 130; i++) begin
         if (!seen_low) begin
            wait_n(1);
            if (!busy) seen_low = 1'b1;
         end
      end
      chk("fs_busy_drop", {31'd0, seen_low}, 32'd1);
      wait_n(300);
      chk("fs_no_byte", cap_cnt - n0, 32'd0);
      chk("fs_busy", {31'd0, busy}, 32'd0);

      // Framing error on 0x3C, then a break, then a clean 0x55.
      n0 = cap_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0);
      wait_n(300);
      chk("fe_count", cap_cnt - n0, 32'd1);
      chk("fe_byte",  {24'd0, cap_byte}, 32'h3C);
      chk("fe_flag",  {31'd0, cap_fe}, 32'd1);
      n0 = cap_cnt;
      rx = 1'b0;
`ifdef UART_RX_PARITY_EN
      wait_n(2 * (BIT * 11 + 102) + 60);
`else
      wait_n(3144);
`endif
      rx = 1'b1;
      wait_n(400);
      chk("brk_count", cap_cnt - n0, 32'd2);
      chk("brk_byte",  {24'd0, cap_byte}, 32'h00);
      chk("brk_fe",    {31'd0, cap_fe}, 32'd1);
      n0 = cap_cnt;
      send_frame(8'h55, 1'b1, 1'b0, -1, 1'b0);
      wait_n(20);
      chk("ok_count", cap_cnt - n0, 32'd1);
      chk("ok_byte",  {24'd0, cap_byte}, 32'h55);
      chk("ok_fe",    {31'd0, cap_fe}, 32'd0);

      // Overrun with consumer stalled.
      ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0, -1, 1'b0);
      wait_n(20);
      chk("ov_valid1", {31'd0, valid}, 32'd1);
      chk("ov_clear1", {31'd0, ov}, 32'd0);
      send_frame(8'h22, 1'b1, 1'b0, -1, 1'b0);
      wait_n(20);
      chk("ov_valid", {31'd0, valid}, 32'd1);
      chk("ov_byte",  {24'd0, rbyte}, 32'h11);
      chk("ov_flag",  {31'd0, ov}, 32'd1);
      n0 = cap_cnt;
      ready = 1'b1;
      wait_n(1);
      chk("ov_xfer_byte", {24'd0, cap_byte}, 32'h11);
      chk("ov_xfer_cnt",  cap_cnt - n0, 32'd1);
      chk("ov_valid_clr", {31'd0, valid}, 32'd0);
      chk("ov_flag_clr",  {31'd0, ov}, 32'd0);

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 has three ones, so parity bit 1 is correct.
      send_frame(8'h07, 1'b1, 1'b1, -1, 1'b0);
      wait_n(20);
      chk("par_good_byte", {24'd0, cap_byte}, 32'h07);
      chk("par_good",      {31'd0, cap_pe}, 32'd0);
      send_frame(8'h07, 1'b1, 1'b0, -1, 1'b0);
      wait_n(20);
      chk("par_bad_byte", {24'd0, cap_byte}, 32'h07);
      chk("par_bad",      {31'd0, cap_pe}, 32'd1);
`else
      chk("par_tied", {31'd0, pe}, 32'd0);
`endif

      // Reset in the middle of data bit 4 of 0xFF.
      wait_n(50);
      rx = 1'b0;
      wait_n(BIT);
      rx = 1'b1;
      wait_n(4 * BIT + 80);
      chk("mid_busy_pre", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_valid", {31'd0, valid}, 32'd0);
      chk("mid_byte",  {24'd0, rbyte}, 32'h00);
      chk("mid_busy",  {31'd0, busy},  32'd0);
      chk("mid_ov",    {31'd0, ov},    32'd0);
      wait_n(5);
      reset_n = 1'b1;
      wait_n(300);
      n0 = cap_cnt;
      send_frame(8'h81, 1'b1, 1'b0, -1, 1'b0);
      wait_n(20);
      chk("post_rst_cnt",  cap_cnt - n0, 32'd1);
      chk("post_rst_byte", {24'd0, cap_byte}, 32'h81);

      // Single-clock glitch at the centre of data bit 3 of 0x00.
      n0 = cap_cnt;
      send_frame(8'h00, 1'b1, 1'b0, 3, 1'b0);
      wait_n(20);
      chk("glitch_cnt",  cap_cnt - n0, 32'd1);
      chk("glitch_byte", {24'd0, cap_byte}, 32'h00);
      chk("glitch_fe",   {31'd0, cap_fe}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
